// File: rtl/dbb_buf_pkg.sv
// Shared types and constants for the DBB read-path credit buffer.
// r_beat_t carries one R beat at the default DBB widths.
package dbb_buf_pkg;

   localparam int unsigned DBB_MAX_BURST = 16;
   localparam int unsigned DBB_ID_W      = 8;
   localparam int unsigned DBB_DATA_W    = 64;

   typedef struct packed {
      logic [DBB_DATA_W-1:0] data;
      logic                  last;
      logic [DBB_ID_W-1:0]   id;
   } r_beat_t;

endpackage

// File: rtl/dbb_r_fifo.sv
// Synchronous show-ahead FIFO. The head entry is always visible on rdata.
// A push into a full FIFO is accepted only together with a pop.
module dbb_r_fifo
   import dbb_buf_pkg::*;
#(
   parameter type         beat_t = r_beat_t,
   parameter int unsigned DEPTH  = 16,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  beat_t         wdata,
   input  logic          pop,
   output beat_t         rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic          do_push_s;
   logic          do_pop_s;
   beat_t         mem_r [DEPTH];

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? {AW{1'b0}} : ptr + AW'(1);
   endfunction

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;
   assign rdata     = mem_r[rd_ptr_r];
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);

   // occupancy update from the accepted push/pop pair
   always_comb begin
      count_nxt_s = count_r;
      case ({do_push_s, do_pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // pointer and occupancy registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
         if (do_pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
         count_r <= count_nxt_s;
      end
   end

   // storage; contents need no reset
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= wdata;
   end

endmodule

// File: rtl/dbb_rd_credit_buffer.sv
// Read-path buffer between NVDLA DBB and axi2mem: AR is forwarded only when every
// beat of the burst has FIFO space reserved, so axi2mem R data is never stalled.
module dbb_rd_credit_buffer
   import dbb_buf_pkg::*;
#(
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned LEN_WIDTH  = 4,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_ar_valid,
   output logic                         s_ar_ready,
   input  logic [ADDR_WIDTH-1:0]        s_ar_addr,
   input  logic [LEN_WIDTH-1:0]         s_ar_len,
   input  logic [ID_WIDTH-1:0]          s_ar_id,
   output logic                         s_r_valid,
   input  logic                         s_r_ready,
   output logic [DATA_WIDTH-1:0]        s_r_data,
   output logic                         s_r_last,
   output logic [ID_WIDTH-1:0]          s_r_id,
   output logic                         m_ar_valid,
   input  logic                         m_ar_ready,
   output logic [ADDR_WIDTH-1:0]        m_ar_addr,
   output logic [LEN_WIDTH-1:0]         m_ar_len,
   output logic [ID_WIDTH-1:0]          m_ar_id,
   input  logic                         m_r_valid,
   output logic                         m_r_ready,
   input  logic [DATA_WIDTH-1:0]        m_r_data,
   input  logic                         m_r_last,
   input  logic [ID_WIDTH-1:0]          m_r_id,
   output logic [$clog2(DEPTH+1)-1:0]   reserved_o,
   output logic                         ovf_err_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   if (DEPTH < (32'd1 << LEN_WIDTH)) begin : g_depth_chk
      $error("dbb_rd_credit_buffer: DEPTH must hold the longest burst");
   end

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
      logic [ID_WIDTH-1:0]   id;
   } beat_t;

   logic [CW-1:0] reserved_r;
   logic [CW-1:0] reserved_nxt_s;
   logic [CW:0]   need_s;
   logic          fits_s;
   logic          ar_fire_s;
   logic          push_s;
   logic          pop_s;
   logic          full_s;
   logic          empty_s;
   logic [CW-1:0] count_s;
   logic          ovf_r;
   beat_t         wbeat_s;
   beat_t         head_s;

   // one extra bit so reserved + len + 1 cannot wrap
   assign need_s    = {1'b0, reserved_r} + (CW+1)'(s_ar_len) + (CW+1)'(1);
   assign fits_s    = (need_s <= (CW+1)'(DEPTH));
   assign m_ar_valid = s_ar_valid & fits_s;
   assign s_ar_ready = m_ar_ready & fits_s;
   assign m_ar_addr  = s_ar_addr;
   assign m_ar_len   = s_ar_len;
   assign m_ar_id    = s_ar_id;
   assign ar_fire_s  = m_ar_valid & m_ar_ready;

   assign m_r_ready = ~full_s;
   assign push_s    = m_r_valid & m_r_ready;
   assign s_r_valid = ~empty_s;
   assign pop_s     = s_r_valid & s_r_ready;
   assign wbeat_s   = '{data: m_r_data, last: m_r_last, id: m_r_id};
   assign s_r_data  = head_s.data;
   assign s_r_last  = head_s.last;
   assign s_r_id    = head_s.id;

   assign reserved_o = reserved_r;
   assign ovf_err_o  = ovf_r;

   // credit arithmetic: add a whole burst on AR fire, release one beat per pop
   always_comb begin
      reserved_nxt_s = reserved_r;
      if (ar_fire_s) begin
         reserved_nxt_s = reserved_nxt_s + CW'(s_ar_len) + CW'(1);
      end else begin
         reserved_nxt_s = reserved_nxt_s;
      end
      if (pop_s) begin
         reserved_nxt_s = reserved_nxt_s - CW'(1);
      end else begin
         reserved_nxt_s = reserved_nxt_s;
      end
   end

   // credit counter and sticky overflow detector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reserved_r <= {CW{1'b0}};
         ovf_r      <= 1'b0;
      end else begin
         reserved_r <= reserved_nxt_s;
         ovf_r      <= ovf_r | (m_r_valid & (count_s == CW'(DEPTH)));
      end
   end

   dbb_r_fifo #(
      .beat_t (beat_t),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .wdata (wbeat_s),
      .pop   (pop_s),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s),
      .count (count_s)
   );

endmodule
